snoop_responder: RTL

Per-CPU snoop agent that answers the coherence bus controller's requests (search, invalidate) against a shadow tag/MSI-state/data directory of that CPU's data cache. One instance sits beside each CPU's d-cache. It returns hit status, block state and forwarded data to the bus, downgrades or invalidates lines, and writes modified blocks back to data memory when configured.

---
 rtl/snoop_responder.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/snoop_responder.sv
// Snoop agent holding a shadow tag/MSI/data directory of one CPU's d-cache; answers bus search/invalidate.
// Define SNOOP_WB_EN to build the writeback path (WB/WB_WAIT states, wb_* ports); otherwise the cache is write-through.
module snoop_responder #(
   parameter int INDEX_W  = 6,
   parameter int ADDR_W   = 13,
   parameter int DATA_W   = 16,
   parameter int HOLD_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              snoop_search,
   input  logic              snoop_inv,
   input  logic [ADDR_W-1:0] snoop_addr,
   output logic              search_found,
   output logic [1:0]        block_state,
   output logic [DATA_W-1:0] fwd_data,
   output logic              fwd_valid,
   output logic              snoop_busy,
   input  logic              lu_we,
   input  logic [ADDR_W-1:0] lu_addr,
   input  logic [DATA_W-1:0] lu_data,
   input  logic [1:0]        lu_state,
   output logic              wb_req,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   input  logic              wb_rdy
);

   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W;

   localparam logic [1:0] MSI_I = 2'b00;
   localparam logic [1:0] MSI_S = 2'b01;
   localparam logic [1:0] MSI_M = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_WB,
      S_WB_WAIT
   } fsm_e;

   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [DATA_W-1:0] data_q [LINES];
   logic [1:0]        msi_q  [LINES];

   fsm_e              fsm_q, fsm_d;
   logic [2:0]        hold_cnt_q, hold_cnt_d;
   logic              found_q, found_d;
   logic [1:0]        bstate_q, bstate_d;
   logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
   logic              fwd_valid_q, fwd_valid_d;

   logic [INDEX_W-1:0] snp_idx;
   logic [INDEX_W-1:0] lu_idx;
   logic [1:0]         snp_msi;
   logic               snp_hit;
   logic               msi_we;
   logic [1:0]         msi_wdata;
   logic               lu_fire;

   assign snp_idx = snoop_addr[INDEX_W-1:0];
   assign lu_idx  = lu_addr[INDEX_W-1:0];
   assign snp_msi = msi_q[snp_idx];
   // State 11 is never a hit: only S and M lines are considered present.
   assign snp_hit = ((snp_msi == MSI_S) || (snp_msi == MSI_M)) &&
                    (tag_q[snp_idx] == snoop_addr[ADDR_W-1:INDEX_W]);

`ifdef SNOOP_WB_EN
   logic              wb_pend_q, wb_pend_d;
   logic              wb_req_q, wb_req_d;
   logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
`endif

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      fsm_d       = fsm_q;
      hold_cnt_d  = hold_cnt_q;
      found_d     = found_q;
      bstate_d    = bstate_q;
      fwd_data_d  = fwd_data_q;
      fwd_valid_d = fwd_valid_q;
      msi_we      = 1'b0;
      msi_wdata   = MSI_I;
      lu_fire     = 1'b0;
`ifdef SNOOP_WB_EN
      wb_pend_d   = wb_pend_q;
      wb_req_d    = wb_req_q;
      wb_addr_d   = wb_addr_q;
      wb_data_d   = wb_data_q;
`endif
      case (fsm_q)
         S_IDLE: begin
            if (snoop_inv) begin
               if (snp_hit) begin
                  msi_we    = 1'b1;
                  msi_wdata = MSI_I;
`ifdef SNOOP_WB_EN
                  if (snp_msi == MSI_M) begin
                     wb_req_d  = 1'b1;
                     wb_addr_d = snoop_addr;
                     wb_data_d = data_q[snp_idx];
                     fsm_d     = S_WB;
                  end
`endif
               end
            end else if (snoop_search) begin
               fsm_d       = S_HOLD;
               hold_cnt_d  = 3'(HOLD_CYC - 1);
               found_d     = snp_hit;
               fwd_valid_d = snp_hit;
               bstate_d    = snp_hit ? snp_msi : MSI_I;
               fwd_data_d  = snp_hit ? data_q[snp_idx] : '0;
               if (snp_hit && (snp_msi == MSI_M)) begin
                  msi_we    = 1'b1;
                  msi_wdata = MSI_S;
`ifdef SNOOP_WB_EN
                  wb_pend_d = 1'b1;
                  wb_addr_d = snoop_addr;
                  wb_data_d = data_q[snp_idx];
`endif
               end
            end else if (lu_we) begin
               lu_fire = 1'b1;
            end
         end
         S_HOLD: begin
            if (hold_cnt_q == 3'd0) begin
               fsm_d       = S_IDLE;
               found_d     = 1'b0;
               bstate_d    = MSI_I;
               fwd_data_d  = '0;
               fwd_valid_d = 1'b0;
`ifdef SNOOP_WB_EN
               if (wb_pend_q) begin
                  fsm_d     = S_WB;
                  wb_req_d  = 1'b1;
                  wb_pend_d = 1'b0;
               end
`endif
            end else begin
               hold_cnt_d = hold_cnt_q - 3'd1;
            end
         end
         S_WB, S_WB_WAIT: begin
`ifdef SNOOP_WB_EN
            if (wb_rdy) begin
               wb_req_d = 1'b0;
               fsm_d    = S_IDLE;
            end else begin
               fsm_d    = S_WB_WAIT;
            end
`else
            fsm_d = S_IDLE;
`endif
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= S_IDLE;
         hold_cnt_q  <= '0;
         found_q     <= 1'b0;
         bstate_q    <= MSI_I;
         fwd_data_q  <= '0;
         fwd_valid_q <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         hold_cnt_q  <= hold_cnt_d;
         found_q     <= found_d;
         bstate_q    <= bstate_d;
         fwd_data_q  <= fwd_data_d;
         fwd_valid_q <= fwd_valid_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LINES; i++) msi_q[i] <= MSI_I;
      end else if (msi_we) begin
         msi_q[snp_idx] <= msi_wdata;
      end else if (lu_fire) begin
         msi_q[lu_idx] <= lu_state;
      end
   end

   // NOTE: tag/data storage has no reset; an I state already marks a line's contents as meaningless.
   always_ff @(posedge clk) begin
      if (lu_fire) begin
         tag_q[lu_idx]  <= lu_addr[ADDR_W-1:INDEX_W];
         data_q[lu_idx] <= lu_data;
      end
   end

`ifdef SNOOP_WB_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_pend_q <= 1'b0;
         wb_req_q  <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else begin
         wb_pend_q <= wb_pend_d;
         wb_req_q  <= wb_req_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign wb_req  = wb_req_q;
   assign wb_addr = wb_addr_q;
   assign wb_data = wb_data_q;
`else
   logic unused_wb_rdy;
   assign unused_wb_rdy = wb_rdy;
   assign wb_req  = 1'b0;
   assign wb_addr = '0;
   assign wb_data = '0;
`endif

   assign search_found = found_q;
   assign block_state  = bstate_q;
   assign fwd_data     = fwd_data_q;
   assign fwd_valid    = fwd_valid_q;
   assign snoop_busy   = (fsm_q != S_IDLE) | snoop_search | snoop_inv;

endmodule
